ov5640_ddr_w_ring_ctrl: RTL
===========================

# ov5640_ddr_w_ring_ctrl

Parametrised camera-frame write controller between the OV5640 capture path and the AXI write-DMA command interface. Rotates through NUM_BUF frame buffers in DDR. Splits each frame into bounded-length write commands. Hands each completed buffer to XDMA through a per-buffer req/ack pair. When the next buffer is still owned by the host, it drops the frame and counts the drop instead of overwriting data the host has not read.

## Interface
Parameters:
- NUM_BUF, 4: number of frame buffers in the ring (2..16).
- ADDR_W, 32: DDR byte-address width.
- LEN_W, 20: frame-length width, in 16-byte units.
- CHUNK_UNITS, 256: maximum length of one command, in 16-byte units (power of two, ≤ 2^LEN_W).
- IDX_W, $clog2(NUM_BUF): buffer-index width.

Ports:
- axi_clk  in  1  single clock for the whole block.
- axi_rst_n  in  1  reset, asynchronous assert, active-low.
- buf_base_addr  in  ADDR_W  byte address of buffer 0.
- buf_stride  in  ADDR_W  byte distance between consecutive buffers.
- cam_data_len  in  LEN_W  frame length in 16-byte units; 0 disables capture.
- s_vsync  in  1  camera vsync, asynchronous to axi_clk.
- axi_data_valid / axi_data_ready / axi_data_last  in  1 each  observed write-data handshake.
- axi_cmd_addr  out  ADDR_W  command byte address.
- axi_cmd_len  out  32  command length in bytes.
- axi_cmd_valid  out  1  command valid.
- axi_cmd_ready  in  1  command ready.
- xdma_req  out  NUM_BUF  bit i = buffer i holds a complete frame for the host.
- xdma_ack  in  NUM_BUF  bit i = host releases buffer i (single-cycle pulse or level).
- wr_buf_idx  out  IDX_W  buffer currently being written, or the next to be written when idle.
- frame_drop_cnt  out  16  saturating count of frames dropped.
- busy  out  1  high when the state is not IDLE.

## Operation
- s_vsync passes through a 2-flop synchroniser. The rising edge is detected into a registered pulse, vs_rise.
- States: IDLE, CMD, DATA.
- IDLE, on vs_rise:
  - If cam_data_len == 0: ignore the pulse.
  - Else if xdma_req[wr_buf_idx] == 1: drop the frame. frame_drop_cnt += 1, saturating at 0xFFFF. Stay in IDLE.
  - Else: latch len_rem = cam_data_len and cur_addr = buf_base_addr + wr_buf_idx*buf_stride (modulo 2^ADDR_W). Go to CMD.
- vs_rise in CMD or DATA is ignored and not counted.
- CMD:
  - axi_cmd_valid = 1.
  - axi_cmd_addr = cur_addr.
  - axi_cmd_len = min(len_rem, CHUNK_UNITS) * 16, zero-extended.
  - Valid, addr and len are held stable until axi_cmd_ready. On the handshake, go to DATA.
- DATA: on axi_data_valid & axi_data_ready & axi_data_last:
  - len_rem -= chunk and cur_addr += chunk*16.
  - If len_rem > 0 after the update: go to CMD.
  - Else: set xdma_req[wr_buf_idx], set wr_buf_idx = (wr_buf_idx+1) mod NUM_BUF, go to IDLE.
- Data beats without last are ignored. Beat counts are not checked.
- xdma_req[i] clears on xdma_ack[i].
  - If a set and an ack for the same bit occur in the same cycle, the set wins.
  - Acks on other bits in that cycle take effect normally.
  - An ack on a bit that is 0 has no effect.
- Inputs buf_base_addr, buf_stride and cam_data_len are sampled only at frame start. Changes mid-frame do not affect the frame in flight.

## Timing
- Reset (axi_rst_n low, asynchronous) sets:
  - state IDLE;
  - axi_cmd_valid, xdma_req, wr_buf_idx, frame_drop_cnt and busy to 0;
  - axi_cmd_addr and axi_cmd_len to 0;
  - the synchroniser to 0.
- Deassertion is consumed synchronously. Reset mid-frame abandons the frame with no req raised.
- s_vsync rising at sample edge E gives vs_rise high on edge E+3. axi_cmd_valid goes high on edge E+4.
- After a command handshake on edge N, the state is DATA from N+1.
- After a non-final last beat on edge N, axi_cmd_valid = 1 from N+1 with the next chunk's address and length.
- After the final last beat on edge N, from N+1: xdma_req bit = 1, wr_buf_idx advanced, busy = 0.
- A new vs_rise can start the next frame on edge N+1.
- A drop decision updates frame_drop_cnt on the edge after vs_rise.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- NUM_BUF=4, CHUNK_UNITS=256, base=0x1000_0000, stride=0x0020_0000, len=600, immediate ready:
  - Three commands: (0x1000_0000, 4096), (0x1000_1000, 4096), (0x1000_2000, 1408).
  - Then xdma_req=0001 and wr_buf_idx=1.
- Four frames with no ack: xdma_req=1111 and wr_buf_idx=0. Fifth vsync: no command, frame_drop_cnt=1. Pulse xdma_ack[0], then vsync: frame is written to 0x1000_0000.
- Final last beat coincident with xdma_ack on the same bit: req stays 1. Same cycle, ack on another set bit: that bit clears.
- cam_data_len=0 with vsync: no command, no drop count. Vsync pulses during DATA: ignored, and the frame completes normally.
- axi_cmd_ready held low for 10 cycles: valid, addr and len stay stable. Change cam_data_len mid-frame: the current frame's lengths are unchanged.
- Assert axi_rst_n low mid-DATA:
  - Outputs reach their reset values without a clock edge.
  - After release, the next frame starts at buffer 0 with xdma_req=0.

Source files
------------

// File: rtl/ov5640_ddr_w_ring_ctrl_if.sv
// Command, write-data observation and host-handoff signals between the frame
// write controller (master) and the DMA/host side (slave).
interface ov5640_ddr_w_ring_ctrl_if #(
   parameter int ADDR_W  = 32,
   parameter int NUM_BUF = 4
);
   logic [ADDR_W-1:0]  axi_cmd_addr;
   logic [31:0]        axi_cmd_len;
   logic               axi_cmd_valid;
   logic               axi_cmd_ready;
   logic               axi_data_valid;
   logic               axi_data_ready;
   logic               axi_data_last;
   logic [NUM_BUF-1:0] xdma_req;
   logic [NUM_BUF-1:0] xdma_ack;

   modport master (
      output axi_cmd_addr, axi_cmd_len, axi_cmd_valid, xdma_req,
      input  axi_cmd_ready, axi_data_valid, axi_data_ready, axi_data_last, xdma_ack
   );

   modport slave (
      input  axi_cmd_addr, axi_cmd_len, axi_cmd_valid, xdma_req,
      output axi_cmd_ready, axi_data_valid, axi_data_ready, axi_data_last, xdma_ack
   );
endinterface

// File: rtl/ov5640_ddr_w_ring_ctrl.sv
// Camera frame write controller: rotates through NUM_BUF DDR buffers, splits each
// frame into bounded write commands and hands finished buffers to the host.
module ov5640_ddr_w_ring_ctrl #(
   parameter int NUM_BUF     = 4,
   parameter int ADDR_W      = 32,
   parameter int LEN_W       = 20,
   parameter int CHUNK_UNITS = 256,
   parameter int IDX_W       = $clog2(NUM_BUF)
) (
   input  logic                 axi_clk,
   input  logic                 axi_rst_n,
   input  logic [ADDR_W-1:0]    buf_base_addr,
   input  logic [ADDR_W-1:0]    buf_stride,
   input  logic [LEN_W-1:0]     cam_data_len,
   input  logic                 s_vsync,
   ov5640_ddr_w_ring_ctrl_if.master bus,
   output logic [IDX_W-1:0]     wr_buf_idx,
   output logic [15:0]          frame_drop_cnt,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

   localparam logic [LEN_W:0] CHUNK_MAX = (LEN_W+1)'(CHUNK_UNITS);

   state_t             state, state_next;
   logic               vs_p0, vs_p1, vs_p2, vs_p3, vs_rise;
   logic [LEN_W-1:0]   len_rem, chunk, rem_after;
   logic [ADDR_W-1:0]  cur_addr;
   logic [NUM_BUF-1:0] req, set_mask;
   logic               start, drop, done, last_beat;

   function automatic logic [LEN_W-1:0] chunk_of(input logic [LEN_W-1:0] rem);
      // min(rem, CHUNK_UNITS) never exceeds rem, so it always fits in LEN_W bits
      if ({1'b0, rem} > CHUNK_MAX)
         return CHUNK_MAX[LEN_W-1:0];
      return rem;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
      return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
   endfunction

   assign chunk     = chunk_of(len_rem);
   assign rem_after = len_rem - chunk;
   assign last_beat = bus.axi_data_valid & bus.axi_data_ready & bus.axi_data_last;
   assign set_mask  = NUM_BUF'(done) << wr_buf_idx;

   assign bus.axi_cmd_valid = (state == CMD);
   assign bus.axi_cmd_addr  = cur_addr;
   assign bus.axi_cmd_len   = 32'({chunk, 4'b0000});
   assign bus.xdma_req      = req;
   assign busy              = (state != IDLE);

   // vsync: p0/p1 synchronise, p2/p3 align the edge detector, vs_rise is the registered pulse
   always_ff @(posedge axi_clk or negedge axi_rst_n) begin
      if (!axi_rst_n) begin
         vs_p0   <= 1'b0;
         vs_p1   <= 1'b0;
         vs_p2   <= 1'b0;
         vs_p3   <= 1'b0;
         vs_rise <= 1'b0;
      end else begin
         vs_p0   <= s_vsync;
         vs_p1   <= vs_p0;
         vs_p2   <= vs_p1;
         vs_p3   <= vs_p2;
         vs_rise <= vs_p2 & ~vs_p3;
      end
   end

   always_comb begin
      state_next = state;
      start      = 1'b0;
      drop       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (vs_rise && cam_data_len != '0) begin
               if (req[wr_buf_idx]) begin
                  drop = 1'b1;
               end else begin
                  start      = 1'b1;
                  state_next = CMD;
               end
            end
         end
         CMD: begin
            if (bus.axi_cmd_ready)
               state_next = DATA;
         end
         DATA: begin
            if (last_beat) begin
               if (rem_after != '0) begin
                  state_next = CMD;
               end else begin
                  done       = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge axi_clk or negedge axi_rst_n) begin
      if (!axi_rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_ff @(posedge axi_clk or negedge axi_rst_n) begin
      if (!axi_rst_n) begin
         len_rem  <= '0;
         cur_addr <= '0;
      end else if (start) begin
         len_rem  <= cam_data_len;
         cur_addr <= buf_base_addr + ADDR_W'(wr_buf_idx) * buf_stride;
      end else if (state == DATA && last_beat) begin
         len_rem  <= rem_after;
         cur_addr <= cur_addr + ADDR_W'({chunk, 4'b0000});
      end
   end

   // A completion set on the same bit as an ack wins; other acks clear normally
   always_ff @(posedge axi_clk or negedge axi_rst_n) begin
      if (!axi_rst_n) begin
         req            <= '0;
         wr_buf_idx     <= '0;
         frame_drop_cnt <= '0;
      end else begin
         req <= (req & ~bus.xdma_ack) | set_mask;
         if (done)
            wr_buf_idx <= (wr_buf_idx == IDX_W'(NUM_BUF-1)) ? '0 : wr_buf_idx + 1'b1;
         if (drop)
            frame_drop_cnt <= sat_inc(frame_drop_cnt);
      end
   end

endmodule
